// File: rtl/csr_hpm_counter_array_if.sv
// ---------------------------------------------------------------------------
// csr_hpm_counter_array_if
//
// Groups the CSR command bus from the EX stage and the monitor debug port of
// the machine-mode counter CSR block.
//
// Signals (direction seen from the counter block, i.e. the slave side):
//   cmd_csr_ex      in   CSR instruction in EX
//   cpu_stat_ex     in   EX-stage execute qualifier
//   csr_ofs_ex      in   CSR address of the pipeline access
//   csr_op2_ex      in   funct3: [2] immediate, [1:0] 01 RW / 10 RS / 11 RC
//   csr_uimm_ex     in   zero-extended immediate operand
//   rs1_sel         in   register operand
//   csr_hit         out  selected address belongs to this block
//   csr_rd_data     out  registered pre-write CSR value
//   csr_radr_en_mon in   monitor read enable
//   csr_radr_mon    in   monitor read address
//   csr_we_mon      in   monitor write enable
//   csr_wadr_mon    in   monitor write address
//   csr_wdata_mon   in   monitor write data
//   csr_rdata_mon   out  combinational read of the selected address
// ---------------------------------------------------------------------------
interface csr_hpm_counter_array_if;
  logic        cmd_csr_ex;
  logic        cpu_stat_ex;
  logic [11:0] csr_ofs_ex;
  logic [2:0]  csr_op2_ex;
  logic [4:0]  csr_uimm_ex;
  logic [31:0] rs1_sel;
  logic        csr_hit;
  logic [31:0] csr_rd_data;
  logic        csr_radr_en_mon;
  logic [11:0] csr_radr_mon;
  logic        csr_we_mon;
  logic [11:0] csr_wadr_mon;
  logic [31:0] csr_wdata_mon;
  logic [31:0] csr_rdata_mon;

  modport master (
    output cmd_csr_ex, cpu_stat_ex, csr_ofs_ex, csr_op2_ex, csr_uimm_ex, rs1_sel,
    output csr_radr_en_mon, csr_radr_mon, csr_we_mon, csr_wadr_mon, csr_wdata_mon,
    input  csr_hit, csr_rd_data, csr_rdata_mon
  );

  modport slave (
    input  cmd_csr_ex, cpu_stat_ex, csr_ofs_ex, csr_op2_ex, csr_uimm_ex, rs1_sel,
    input  csr_radr_en_mon, csr_radr_mon, csr_we_mon, csr_wadr_mon, csr_wdata_mon,
    output csr_hit, csr_rd_data, csr_rdata_mon
  );
endinterface

// File: rtl/csr_hpm_counter_array.sv
// ---------------------------------------------------------------------------
// csr_hpm_counter_array
//
// Machine-mode counter CSRs: mcycle, minstret and NUM_HPM programmable
// hardware performance counters with event selectors, mcountinhibit,
// read-only user shadows and a sticky overflow register driving an
// interrupt.
//
// Ports:
//   clk           clock
//   rst           asynchronous active-high reset
//   bus           CSR pipeline command + monitor port (slave modport)
//   inst_retire   one instruction retired this cycle
//   events_in     event pulses, one count per high cycle
//   cntr_ovf_int  registered OR of the overflow bits
//
// Counter storage slot k maps to CSR counter index cntIdx(k):
//   k = 0 -> 0 (mcycle), k = 1 -> 2 (minstret), k >= 2 -> k + 1 (mhpmcounterN)
// ---------------------------------------------------------------------------
module csr_hpm_counter_array #(
  parameter int NUM_HPM    = 4,
  parameter int CNT_WIDTH  = 64,
  parameter int NUM_EVENTS = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  csr_hpm_counter_array_if.slave  bus,
  input  logic                    inst_retire,
  input  logic [NUM_EVENTS-1:0]   events_in,
  output logic                    cntr_ovf_int
);

  localparam int NC = NUM_HPM + 2;
  localparam int EW = $clog2(NUM_EVENTS + 1);
  localparam int HW = CNT_WIDTH - 32;

  function automatic int cntIdx(input int k);
    return (k == 0) ? 0 : k + 1;
  endfunction

  function automatic logic [31:0] implMask();
    logic [31:0] m;
    m = '0;
    for (int k = 0; k < NC; k++) m[5'(cntIdx(k))] = 1'b1;
    return m;
  endfunction

  // Implemented bit positions of mcountinhibit and mcntovf
  localparam logic [31:0] IMPL = implMask();

  logic [CNT_WIDTH-1:0] r_cnt [NC];
  logic [EW-1:0]        r_evt [NUM_HPM];
  logic [31:0]          r_inh;
  logic [31:0]          r_ovf;
  logic [31:0]          r_rdData;
  logic                 r_int;

  function automatic logic csrShadow(input logic [11:0] adr);
    logic s;
    s = 1'b0;
    for (int k = 0; k < NC; k++) begin
      if (adr == 12'hC00 + 12'(cntIdx(k)) || adr == 12'hC80 + 12'(cntIdx(k))) s = 1'b1;
    end
    return s;
  endfunction

  function automatic logic csrHit(input logic [11:0] adr);
    logic h;
    h = csrShadow(adr) || adr == 12'h320 || adr == 12'h7C0;
    for (int k = 0; k < NC; k++) begin
      if (adr == 12'hB00 + 12'(cntIdx(k)) || adr == 12'hB80 + 12'(cntIdx(k))) h = 1'b1;
    end
    for (int j = 0; j < NUM_HPM; j++) begin
      if (adr == 12'h323 + 12'(j)) h = 1'b1;
    end
    return h;
  endfunction

  function automatic logic [31:0] hiHalf(input logic [CNT_WIDTH-1:0] c);
    logic [31:0] h;
    h = '0;
    h[HW-1:0] = c[CNT_WIDTH-1:32];
    return h;
  endfunction

  // Read mux shared by the monitor port and the pipeline old-value capture;
  // unmapped addresses read as zero.
  function automatic logic [31:0] csrRead(input logic [11:0] adr);
    logic [31:0] d;
    d = '0;
    for (int k = 0; k < NC; k++) begin
      if (adr == 12'hB00 + 12'(cntIdx(k)) || adr == 12'hC00 + 12'(cntIdx(k)))
        d = r_cnt[k][31:0];
      if (adr == 12'hB80 + 12'(cntIdx(k)) || adr == 12'hC80 + 12'(cntIdx(k)))
        d = hiHalf(r_cnt[k]);
    end
    for (int j = 0; j < NUM_HPM; j++) begin
      if (adr == 12'h323 + 12'(j)) d = 32'(r_evt[j]);
    end
    if (adr == 12'h320) d = r_inh;
    if (adr == 12'h7C0) d = r_ovf;
    return d;
  endfunction

  logic [11:0] w_selAdr;
  logic        w_pipeHit;
  logic        w_pipeShadow;
  logic [31:0] w_pipeOld;
  logic        w_pipeStb;
  logic        w_monOk;
  logic [31:0] w_opnd;
  logic        w_wrEn;
  logic [11:0] w_wrAdr;
  logic [31:0] w_wrData;

  assign w_selAdr = bus.csr_radr_en_mon ? bus.csr_radr_mon :
                    bus.csr_we_mon      ? bus.csr_wadr_mon : bus.csr_ofs_ex;

  assign bus.csr_hit       = csrHit(w_selAdr);
  assign bus.csr_rdata_mon = csrRead(w_selAdr);
  assign bus.csr_rd_data   = r_rdData;
  assign cntr_ovf_int      = r_int;

  // The pipeline access decodes its own address so that a concurrent
  // monitor write to a different CSR cannot redirect it.
  assign w_pipeHit    = csrHit(bus.csr_ofs_ex);
  assign w_pipeShadow = csrShadow(bus.csr_ofs_ex);
  assign w_pipeOld    = csrRead(bus.csr_ofs_ex);
  assign w_pipeStb    = bus.cmd_csr_ex & bus.cpu_stat_ex & w_pipeHit;
  assign w_monOk      = bus.csr_we_mon & csrHit(bus.csr_wadr_mon) & ~csrShadow(bus.csr_wadr_mon);
  assign w_opnd       = bus.csr_op2_ex[2] ? {27'b0, bus.csr_uimm_ex} : bus.rs1_sel;

  // Single resolved write port: the pipeline wins, the monitor only writes
  // in cycles with no pipeline strobe. Shadow addresses are never written.
  always_comb begin
    w_wrEn   = 1'b0;
    w_wrAdr  = bus.csr_ofs_ex;
    w_wrData = w_pipeOld;
    if (w_pipeStb) begin
      w_wrEn = (bus.csr_op2_ex[1:0] != 2'b00) && !w_pipeShadow;
      case (bus.csr_op2_ex[1:0])
        2'b01:   w_wrData = w_opnd;
        2'b10:   w_wrData = w_pipeOld | w_opnd;
        2'b11:   w_wrData = w_pipeOld & ~w_opnd;
        default: w_wrData = w_pipeOld;
      endcase
    end else if (w_monOk) begin
      w_wrEn   = 1'b1;
      w_wrAdr  = bus.csr_wadr_mon;
      w_wrData = bus.csr_wdata_mon;
    end
  end

  logic        w_loWr [NC];
  logic        w_hiWr [NC];
  logic        w_inc  [NC];
  logic        w_evtHit [NUM_HPM];
  logic        w_evtWr  [NUM_HPM];
  logic [31:0] w_ovfSet;
  logic        w_inhWr;
  logic        w_ovfWr;

  // Event selection: a one-hot of the selector lined up against the events
  // shifted up by one, so selector 0 lands on a constant zero.
  always_comb begin
    for (int j = 0; j < NUM_HPM; j++) begin
      w_evtHit[j] = |({events_in, 1'b0} & ((NUM_EVENTS + 1)'(1) << r_evt[j]));
      w_evtWr[j]  = w_wrEn && (w_wrAdr == 12'h323 + 12'(j));
    end
  end

  // Per-counter write decode, increment enable and wrap detection; a write
  // to either half of a counter blocks that counter's increment.
  always_comb begin
    w_ovfSet = '0;
    for (int k = 0; k < NC; k++) begin
      w_loWr[k] = w_wrEn && (w_wrAdr == 12'hB00 + 12'(cntIdx(k)));
      w_hiWr[k] = w_wrEn && (w_wrAdr == 12'hB80 + 12'(cntIdx(k)));
      w_inc[k]  = !r_inh[5'(cntIdx(k))] && !w_loWr[k] && !w_hiWr[k] &&
                  ((k == 0) ? 1'b1 : (k == 1) ? inst_retire : w_evtHit[(k < 2) ? 0 : k - 2]);
      w_ovfSet[5'(cntIdx(k))] = w_inc[k] && (&r_cnt[k]);
    end
  end

  assign w_inhWr = w_wrEn && (w_wrAdr == 12'h320);
  assign w_ovfWr = w_wrEn && (w_wrAdr == 12'h7C0);

  // Counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NC; k++) r_cnt[k] <= '0;
    end else begin
      for (int k = 0; k < NC; k++) begin
        if (w_loWr[k])      r_cnt[k][31:0]           <= w_wrData;
        else if (w_hiWr[k]) r_cnt[k][CNT_WIDTH-1:32] <= w_wrData[HW-1:0];
        else if (w_inc[k])  r_cnt[k]                 <= r_cnt[k] + CNT_WIDTH'(1);
      end
    end
  end

  // Event selectors: out-of-range selections store zero
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int j = 0; j < NUM_HPM; j++) r_evt[j] <= '0;
    end else begin
      for (int j = 0; j < NUM_HPM; j++) begin
        if (w_evtWr[j])
          r_evt[j] <= (w_wrData > 32'(NUM_EVENTS)) ? '0 : w_wrData[EW-1:0];
      end
    end
  end

  // Inhibit, sticky overflow (set beats clear), read capture and interrupt
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_inh    <= '0;
      r_ovf    <= '0;
      r_rdData <= '0;
      r_int    <= 1'b0;
    end else begin
      if (w_inhWr) r_inh <= w_wrData & IMPL;
      r_ovf <= ((w_ovfWr ? w_wrData : r_ovf) & IMPL) | w_ovfSet;
      if (w_pipeStb) r_rdData <= w_pipeOld;
      r_int <= |r_ovf;
    end
  end

endmodule

// File: tb/tb_csr_hpm_counter_array.sv
// ---------------------------------------------------------------------------
// tb_csr_hpm_counter_array
//
// Directed bench for csr_hpm_counter_array with default parameters
// (NUM_HPM = 4, CNT_WIDTH = 64, NUM_EVENTS = 8). Inputs change on the falling
// clock edge; outputs are sampled shortly after it.
// ---------------------------------------------------------------------------
module tb_csr_hpm_counter_array;

  logic       clk;
  logic       rst;
  logic       inst_retire;
  logic [7:0] events_in;
  logic       cntr_ovf_int;

  int vectors     = 0;
  int miscompares = 0;

  csr_hpm_counter_array_if bus ();

  csr_hpm_counter_array #(
    .NUM_HPM    (4),
    .CNT_WIDTH  (64),
    .NUM_EVENTS (8)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .inst_retire  (inst_retire),
    .events_in    (events_in),
    .cntr_ovf_int (cntr_ovf_int)
  );

  // 10-unit clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Every comparison goes through here
  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, act, exp);
    end
  endtask

  // One pipeline CSR instruction, held for one rising edge
  task automatic applyStimulus(input logic [2:0] op, input logic [11:0] adr,
                               input logic [31:0] rs1, input logic [4:0] uimm);
    bus.cmd_csr_ex  = 1'b1;
    bus.cpu_stat_ex = 1'b1;
    bus.csr_op2_ex  = op;
    bus.csr_ofs_ex  = adr;
    bus.rs1_sel     = rs1;
    bus.csr_uimm_ex = uimm;
    @(negedge clk);
    bus.cmd_csr_ex  = 1'b0;
    bus.cpu_stat_ex = 1'b0;
  endtask

  task automatic monWrite(input logic [11:0] adr, input logic [31:0] data);
    bus.csr_we_mon    = 1'b1;
    bus.csr_wadr_mon  = adr;
    bus.csr_wdata_mon = data;
    @(negedge clk);
    bus.csr_we_mon    = 1'b0;
  endtask

  // Combinational monitor read; costs one time unit, no clock edge
  task automatic monRead(input logic [11:0] adr, output logic [31:0] data, output logic hit);
    bus.csr_radr_en_mon = 1'b1;
    bus.csr_radr_mon    = adr;
    #1;
    data = bus.csr_rdata_mon;
    hit  = bus.csr_hit;
    bus.csr_radr_en_mon = 1'b0;
  endtask

  task automatic checkRead(input string tag, input logic [11:0] adr, input logic [31:0] exp);
    logic [31:0] d;
    logic        h;
    monRead(adr, d, h);
    checkOutput(tag, d, exp);
  endtask

  logic [31:0] rdVal;
  logic        rdHit;

  initial begin
    rst = 1'b0;
    inst_retire = 1'b0;
    events_in = '0;
    bus.cmd_csr_ex = 1'b0;
    bus.cpu_stat_ex = 1'b0;
    bus.csr_ofs_ex = '0;
    bus.csr_op2_ex = '0;
    bus.csr_uimm_ex = '0;
    bus.rs1_sel = '0;
    bus.csr_radr_en_mon = 1'b0;
    bus.csr_radr_mon = '0;
    bus.csr_we_mon = 1'b0;
    bus.csr_wadr_mon = '0;
    bus.csr_wdata_mon = '0;
    #1 rst = 1'b1;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    checkOutput("rst_hit",   32'(bus.csr_hit), 32'd0);
    checkOutput("rst_rdata", bus.csr_rd_data, 32'd0);
    checkOutput("rst_int",   32'(cntr_ovf_int), 32'd0);
    checkRead("rst_mcycle", 12'hB00, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Ten idle cycles after release
    repeat (10) @(negedge clk);
    checkRead("mcycle_10", 12'hB00, 32'd10);
    checkRead("minstret_0", 12'hB02, 32'd0);

    // Event selector and HPM3 counting
    applyStimulus(3'b001, 12'h323, 32'd2, 5'd0);
    checkOutput("evt3_old", bus.csr_rd_data, 32'd0);
    events_in = 8'h02;
    repeat (5) @(negedge clk);
    events_in = 8'h01;
    repeat (3) @(negedge clk);
    events_in = 8'h00;
    checkRead("hpm3_5", 12'hB03, 32'd5);
    applyStimulus(3'b101, 12'h323, 32'd0, 5'd8);
    checkOutput("evt3_old2", bus.csr_rd_data, 32'd2);
    checkRead("evt3_8", 12'h323, 32'd8);
    applyStimulus(3'b101, 12'h323, 32'd0, 5'd9);
    checkOutput("evt3_old8", bus.csr_rd_data, 32'd8);
    checkRead("evt3_9to0", 12'h323, 32'd0);
    events_in = 8'hFF;
    repeat (2) @(negedge clk);
    events_in = 8'h00;
    checkRead("hpm3_sel0", 12'hB03, 32'd5);

    // mcountinhibit on minstret
    applyStimulus(3'b010, 12'h320, 32'd4, 5'd0);
    checkOutput("inh_old", bus.csr_rd_data, 32'd0);
    checkRead("inh_rs", 12'h320, 32'd4);
    inst_retire = 1'b1;
    repeat (4) @(negedge clk);
    inst_retire = 1'b0;
    checkRead("minstret_inh", 12'hB02, 32'd0);
    applyStimulus(3'b111, 12'h320, 32'd0, 5'd4);
    checkOutput("inh_rc_old", bus.csr_rd_data, 32'd4);
    inst_retire = 1'b1;
    @(negedge clk);
    inst_retire = 1'b0;
    checkRead("minstret_1", 12'hB02, 32'd1);
    applyStimulus(3'b001, 12'h320, 32'hFFFF_FFFF, 5'd0);
    checkRead("inh_warl", 12'h320, 32'h0000_007D);
    applyStimulus(3'b001, 12'h320, 32'd0, 5'd0);
    checkOutput("inh_old7d", bus.csr_rd_data, 32'h0000_007D);

    // mcycle wrap and overflow interrupt
    applyStimulus(3'b001, 12'hB80, 32'hFFFF_FFFF, 5'd0);
    checkOutput("mcycleh_old", bus.csr_rd_data, 32'd0);
    applyStimulus(3'b001, 12'hB00, 32'hFFFF_FFFE, 5'd0);
    checkRead("mcycle_wr", 12'hB00, 32'hFFFF_FFFE);
    checkRead("mcycleh_wr", 12'hB80, 32'hFFFF_FFFF);
    @(negedge clk);
    checkRead("mcycle_ff", 12'hB00, 32'hFFFF_FFFF);
    checkRead("ovf_pre", 12'h7C0, 32'd0);
    @(negedge clk);
    checkRead("mcycle_wrap", 12'hB00, 32'd0);
    checkRead("mcycleh_wrap", 12'hB80, 32'd0);
    checkRead("ovf_set", 12'h7C0, 32'd1);
    checkOutput("int_lag", 32'(cntr_ovf_int), 32'd0);
    @(negedge clk);
    checkOutput("int_set", 32'(cntr_ovf_int), 32'd1);
    applyStimulus(3'b111, 12'h7C0, 32'd0, 5'd1);
    checkOutput("ovf_old", bus.csr_rd_data, 32'd1);
    checkRead("ovf_clr", 12'h7C0, 32'd0);
    @(negedge clk);
    checkOutput("int_drop", 32'(cntr_ovf_int), 32'd0);

    // Write during counting: old value captured, no increment on write
    applyStimulus(3'b001, 12'hB00, 32'd100, 5'd0);
    checkRead("mcycle_100", 12'hB00, 32'd100);
    repeat (3) @(negedge clk);
    applyStimulus(3'b001, 12'hB00, 32'h0000_5000, 5'd0);
    checkOutput("mcycle_old", bus.csr_rd_data, 32'd103);
    checkRead("mcycle_new", 12'hB00, 32'h0000_5000);
    @(negedge clk);
    checkRead("mcycle_next", 12'hB00, 32'h0000_5001);

    // Monitor write collides with a pipeline write
    bus.csr_we_mon    = 1'b1;
    bus.csr_wadr_mon  = 12'hB03;
    bus.csr_wdata_mon = 32'h0000_1234;
    applyStimulus(3'b001, 12'hB04, 32'h0000_ABCD, 5'd0);
    bus.csr_we_mon    = 1'b0;
    checkOutput("hpm4_old", bus.csr_rd_data, 32'd0);
    checkRead("hpm4_pipe", 12'hB04, 32'h0000_ABCD);
    checkRead("hpm3_kept", 12'hB03, 32'd5);
    monWrite(12'hB03, 32'h0000_1234);
    monRead(12'hC03, rdVal, rdHit);
    checkOutput("shadow_rd", rdVal, 32'h0000_1234);
    checkOutput("shadow_hit", 32'(rdHit), 32'd1);
    monWrite(12'hC03, 32'h0000_9999);
    checkRead("shadow_ro", 12'hB03, 32'h0000_1234);
    monRead(12'hB01, rdVal, rdHit);
    checkOutput("unmap_rd", rdVal, 32'd0);
    checkOutput("unmap_hit", 32'(rdHit), 32'd0);

    // op 00 captures the old value but writes nothing
    applyStimulus(3'b000, 12'hB04, 32'hFFFF_FFFF, 5'd0);
    checkOutput("op00_old", bus.csr_rd_data, 32'h0000_ABCD);
    checkRead("op00_keep", 12'hB04, 32'h0000_ABCD);

    // Set overflow by software, then reset mid-operation
    applyStimulus(3'b101, 12'h7C0, 32'd0, 5'd1);
    applyStimulus(3'b110, 12'h7C0, 32'd0, 5'd4);
    checkOutput("ovf_sw_old", bus.csr_rd_data, 32'd1);
    checkOutput("int_sw", 32'(cntr_ovf_int), 32'd1);
    rst = 1'b1;
    #1;
    checkOutput("mid_rst_int", 32'(cntr_ovf_int), 32'd0);
    checkOutput("mid_rst_rd", bus.csr_rd_data, 32'd0);
    checkRead("mid_rst_hpm3", 12'hB03, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checkRead("post_rst_mcycle", 12'hB00, 32'd3);
    checkRead("post_rst_ovf", 12'h7C0, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/csr_hpm_counter_array.md
Name: csr_hpm_counter_array

Overview:
- Parametrised machine-mode counter CSR block, the companion of the core CSR array.
- Implements mcycle/minstret plus NUM_HPM programmable hardware performance counters with event selectors, mcountinhibit, read-only user shadows, and a sticky overflow interrupt.
- Sits in the EX stage beside the core CSR array and uses the same CSR command encoding and monitor debug port.

Parameters:
NUM_HPM, 4, number of mhpmcounterN/mhpmeventN pairs, N = 3..NUM_HPM+2, legal 1..29
CNT_WIDTH, 64, implemented counter width, legal 33..64
NUM_EVENTS, 8, width of events_in, legal 1..31

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
cmd_csr_ex  in  1  CSR instruction in EX
cpu_stat_ex  in  1  EX-stage execute qualifier
csr_ofs_ex  in  12  CSR address
csr_op2_ex  in  3  funct3: [2] = immediate; [1:0] 01 = RW, 10 = RS, 11 = RC
csr_uimm_ex  in  5  zero-extended immediate operand
rs1_sel  in  32  register operand
csr_hit  out  1  decoded address belongs to this block (combinational)
csr_rd_data  out  32  registered old CSR value
inst_retire  in  1  one instruction retired this cycle
events_in  in  NUM_EVENTS  event pulses, one count per high cycle
csr_radr_en_mon  in  1  monitor read enable
csr_radr_mon  in  12  monitor read address
csr_we_mon  in  1  monitor write enable
csr_wadr_mon  in  12  monitor write address
csr_wdata_mon  in  32  monitor write data
csr_rdata_mon  out  32  combinational read of selected address
cntr_ovf_int  out  1  OR of mcntovf bits

Behaviour:
- Address select: csr_radr_en_mon ? csr_radr_mon : csr_we_mon ? csr_wadr_mon : csr_ofs_ex.
- Map, counter index i ∈ {0, 2, 3..NUM_HPM+2}:
  - mcycle 0xB00, minstret 0xB02, mhpmcounterN 0xB00+N; high halves at +0x80.
  - Read-only shadows at 0xC00+i and 0xC80+i.
  - mhpmeventN 0x320+N; mcountinhibit 0x320.
  - mcntovf 0x7C0 (custom).
- Unmapped addresses: read 0, csr_hit = 0. Shadows: hit = 1, writes ignored.
- Write data:
  - Operand v = immediate ? uimm : rs1_sel.
  - RW writes v; RS writes old|v; RC writes old&~v; op 00 writes nothing.
  - Pipeline write strobe = cmd_csr_ex & cpu_stat_ex & hit. Monitor write = csr_we_mon & hit when no pipeline write that cycle.
- csr_rd_data: captures the pre-write value on each pipeline strobe (1-cycle latency); holds otherwise; reset 0.
- Counters:
  - Each counter is CNT_WIDTH bits, reset 0.
  - Low-half write sets bits [31:0]; high-half write sets [CNT_WIDTH-1:32] and drops excess bits.
  - High-half read is zero-extended.
  - A write to either half in a cycle suppresses that counter's increment that cycle.
  - Increment conditions when not inhibited:
    - mcycle: every cycle.
    - minstret: when inst_retire.
    - HPM N: when events_in[sel-1] with sel = mhpmeventN in 1..NUM_EVENTS; sel = 0 never counts.
  - Increment is +1 modulo 2^CNT_WIDTH.
- mhpmeventN (WARL):
  - Stores clog2(NUM_EVENTS+1) bits.
  - A written value > NUM_EVENTS stores 0. Reads zero-extended. Reset 0.
- mcountinhibit (WARL):
  - Implemented bits are 0, 2, 3..NUM_HPM+2; bit 1 and unimplemented bits read 0. Reset 0.
  - An inhibit write takes effect from the following cycle.
- mcntovf:
  - Bit i sets when counter i wraps from all-ones to 0 by increment. A write that produces 0 does not set it.
  - Set has priority over a same-cycle clear of that bit.
  - Writable with RW/RS/RC; implemented bits as mcountinhibit. Reset 0.
- cntr_ovf_int: registered OR of mcntovf, reset 0.
- Reset mid-operation: every register and output returns to 0 asynchronously; counting resumes on the first clock after rst deasserts.

Test Plan:
- Reset release, 10 idle cycles -> mcycle reads 10 (±0 at the defined sample point); minstret 0; all outputs 0 during rst.
- CSRRW mhpmevent3 = 2, pulse events_in[1] 5 cycles, events_in[0] 3 cycles -> mhpmcounter3 = 5; write 9 with NUM_EVENTS = 8 -> reads 0.
- CSRRS mcountinhibit bit 2, 4 retires -> minstret unchanged; CSRRC clears it -> next retire increments.
- Write mcycleh = 0xFFFFFFFF and mcycle = 0xFFFFFFFE -> two cycles later wraps to 0, mcntovf[0] = 1, cntr_ovf_int = 1 next cycle; CSRRC mcntovf 1 -> int drops.
- CSRRW to mcycle during counting -> csr_rd_data holds the old value next cycle; counter equals the written value (no +1) that cycle.
- Monitor write 0xB03 = 0x1234 while a pipeline CSR write hits 0xB04 -> only 0xB04 is updated; monitor read 0xC03 returns the counter; write to 0xC03 is ignored.
